// File: rtl/ej32_au_stk_pkg.sv
// Shared opcode encoding and per-opcode stack requirements for the eJ32 arithmetic unit.
package ej32_au_stk_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,  OP_PUSH = 5'd1,  OP_DUP  = 5'd2,  OP_DROP = 5'd3,
    OP_SWAP = 5'd4,  OP_OVER = 5'd5,  OP_ADD  = 5'd6,  OP_SUB  = 5'd7,
    OP_MUL  = 5'd8,  OP_DIV  = 5'd9,  OP_REM  = 5'd10, OP_AND  = 5'd11,
    OP_OR   = 5'd12, OP_XOR  = 5'd13, OP_SHL  = 5'd14, OP_SHR  = 5'd15,
    OP_USHR = 5'd16, OP_NEG  = 5'd17
  } au_op_t;

  typedef enum logic {DV_IDLE = 1'b0, DV_RUN = 1'b1} div_state_t;

  // Entries that must already be on the stack for the op to execute.
  function automatic logic [1:0] au_need(au_op_t op);
    case (op)
      OP_DUP, OP_DROP, OP_NEG: au_need = 2'd1;
      OP_SWAP, OP_OVER, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_REM,
      OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_USHR: au_need = 2'd2;
      default: au_need = 2'd0;
    endcase
  endfunction

  function automatic logic signed [1:0] au_net(au_op_t op);
    case (op)
      OP_PUSH, OP_DUP, OP_OVER: au_net = 2'sd1;
      OP_DROP, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_REM,
      OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_USHR: au_net = -2'sd1;
      default: au_net = 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/ej32_au_stk_if.sv
// Decoder-facing command/status bundle of the eJ32 arithmetic unit.
interface ej32_au_stk_if #(parameter int DSZ = 32, parameter int DEPTH = 32);
  localparam int DW = $clog2(DEPTH + 1);

  logic          valid_i;
  logic          ready_o;
  logic [4:0]    op_i;
  logic [DSZ-1:0] imm_i;
  logic          err_clr;
  logic [DSZ-1:0] t_o;
  logic [DSZ-1:0] s_o;
  logic [DW-1:0] depth_o;
  logic          ovf_o;
  logic          unf_o;
  logic          div0_o;

  modport master (output valid_i, op_i, imm_i, err_clr,
                  input  ready_o, t_o, s_o, depth_o, ovf_o, unf_o, div0_o);
  modport slave  (input  valid_i, op_i, imm_i, err_clr,
                  output ready_o, t_o, s_o, depth_o, ovf_o, unf_o, div0_o);
endinterface

// File: rtl/ej32_au_stk_div_iter.sv
// Iterative signed restoring divider: one quotient bit per clock, Java truncating semantics.
module ej32_div_iter
  import ej32_au_stk_pkg::*;
#(
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [DSZ-1:0] i_dvd,
  input  logic [DSZ-1:0] i_dvs,
  output logic           o_busy,
  output logic           o_done,
  output logic [DSZ-1:0] o_q,
  output logic [DSZ-1:0] o_r
);
  localparam int CW = $clog2(DSZ);

  div_state_t     r_state, w_state_next;
  logic [CW-1:0]  r_cnt;
  logic [DSZ-1:0] r_rem, r_quo, r_dvs;
  logic           r_negq, r_negr;
  logic [DSZ:0]   w_shift, w_diff;
  logic           w_ge, w_last;
  logic [DSZ-1:0] w_rem_n, w_quo_n;

  // Result is taken from the final iteration's next values so it lands on the same edge busy drops.
  always_comb begin
    w_shift = {r_rem, r_quo[DSZ-1]};
    w_diff  = w_shift - {1'b0, r_dvs};
    w_ge    = ~w_diff[DSZ];
    w_rem_n = w_ge ? w_diff[DSZ-1:0] : w_shift[DSZ-1:0];
    w_quo_n = {r_quo[DSZ-2:0], w_ge};
    w_last  = (r_state == DV_RUN) && (r_cnt == CW'(DSZ - 1));
    o_busy  = (r_state == DV_RUN);
    o_done  = w_last;
    o_q     = r_negq ? -w_quo_n : w_quo_n;
    o_r     = r_negr ? -w_rem_n : w_rem_n;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DV_IDLE: if (i_start) w_state_next = DV_RUN;
      DV_RUN:  if (w_last)  w_state_next = DV_IDLE;
      default: w_state_next = DV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DV_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == DV_IDLE && i_start) begin
        r_cnt  <= '0;
        r_rem  <= '0;
        r_quo  <= i_dvd[DSZ-1] ? -i_dvd : i_dvd;
        r_dvs  <= i_dvs[DSZ-1] ? -i_dvs : i_dvs;
        r_negq <= i_dvd[DSZ-1] ^ i_dvs[DSZ-1];
        r_negr <= i_dvd[DSZ-1];
      end else if (r_state == DV_RUN) begin
        r_cnt <= r_cnt + CW'(1);
        r_rem <= w_rem_n;
        r_quo <= w_quo_n;
      end
    end
  end
endmodule

// File: rtl/ej32_au_stk.sv
// eJ32 stack arithmetic unit: T/S held in registers, deeper entries in a spill array.
module ej32_au_stk
  import ej32_au_stk_pkg::*;
#(
  parameter int DSZ   = 32,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  ej32_au_stk_if.slave au
);
  localparam int DW  = $clog2(DEPTH + 1);
  localparam int SHW = $clog2(DSZ);
  localparam int AW  = (DEPTH - 2 > 1) ? $clog2(DEPTH - 2) : 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  logic [DSZ-1:0] r_t, r_s;
  logic [DW-1:0]  r_depth;
  logic           r_ovf, r_unf, r_div0, r_rem_op;
  logic [DSZ-1:0] r_spill [DEPTH-2];

  au_op_t          w_op;
  logic [1:0]      w_need;
  logic signed [1:0] w_net;
  logic            w_ready, w_acc, w_unf, w_ovf, w_go, w_is_div, w_t_zero;
  logic            w_div_start, w_div0, w_div_busy, w_div_done, w_clr;
  logic            w_push, w_pop, w_swap, w_set_t;
  logic [DSZ-1:0]  w_alu, w_new_t, w_spill_rd, w_div_q, w_div_r;
  logic [SHW-1:0]  w_sh;
  logic [AW-1:0]   w_wr_idx, w_rd_idx;

  ej32_div_iter #(.DSZ(DSZ)) u_div (
    .clk(clk), .rst(rst), .i_start(w_div_start), .i_dvd(r_s), .i_dvs(r_t),
    .o_busy(w_div_busy), .o_done(w_div_done), .o_q(w_div_q), .o_r(w_div_r)
  );

  always_comb begin
    w_ready     = ~w_div_busy;
    w_op        = au_op_t'(au.op_i);
    w_acc       = au.valid_i && w_ready;
    w_clr       = au.err_clr && w_ready;
    w_need      = au_need(w_op);
    w_net       = au_net(w_op);
    w_unf       = w_acc && (r_depth < DW'(w_need));
    w_ovf       = w_acc && !w_unf && (w_net == 2'sd1) && (r_depth == FULL);
    w_go        = w_acc && !w_unf && !w_ovf;
    w_is_div    = (w_op == OP_DIV) || (w_op == OP_REM);
    w_t_zero    = (r_t == '0);
    w_div_start = w_go && w_is_div && !w_t_zero;
    w_div0      = w_go && w_is_div && w_t_zero;
    w_sh        = r_t[SHW-1:0];
    w_wr_idx    = AW'(r_depth - DW'(2));
    w_rd_idx    = AW'(r_depth - DW'(3));
    w_spill_rd  = (r_depth >= DW'(3)) ? r_spill[w_rd_idx] : '0;
  end

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = r_s + r_t;
      OP_SUB:  w_alu = r_s - r_t;
      OP_MUL:  w_alu = r_s * r_t;
      OP_AND:  w_alu = r_s & r_t;
      OP_OR:   w_alu = r_s | r_t;
      OP_XOR:  w_alu = r_s ^ r_t;
      OP_SHL:  w_alu = r_s << w_sh;
      OP_SHR:  w_alu = $signed(r_s) >>> w_sh;
      OP_USHR: w_alu = r_s >> w_sh;
      default: w_alu = '0;
    endcase
  end

  // A finishing divide owns the stack update; no new op can be accepted in that cycle.
  always_comb begin
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_swap  = 1'b0;
    w_set_t = 1'b0;
    w_new_t = r_t;
    if (w_div_done) begin
      w_pop   = 1'b1;
      w_new_t = r_rem_op ? w_div_r : w_div_q;
    end else if (w_go) begin
      case (w_op)
        OP_PUSH: begin w_push = 1'b1; w_new_t = au.imm_i; end
        OP_DUP:  begin w_push = 1'b1; w_new_t = r_t; end
        OP_OVER: begin w_push = 1'b1; w_new_t = r_s; end
        OP_DROP: begin w_pop  = 1'b1; w_new_t = r_s; end
        OP_SWAP: w_swap = 1'b1;
        OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_USHR:
          begin w_pop = 1'b1; w_new_t = w_alu; end
        OP_DIV:  if (w_t_zero) begin w_pop = 1'b1; w_new_t = '1; end
        OP_REM:  if (w_t_zero) begin w_pop = 1'b1; w_new_t = r_s; end
        OP_NEG:  begin w_set_t = 1'b1; w_new_t = '0 - r_t; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && r_depth >= DW'(2)) r_spill[w_wr_idx] <= r_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t      <= '0;
      r_s      <= '0;
      r_depth  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_div0   <= 1'b0;
      r_rem_op <= 1'b0;
    end else begin
      if (w_push) begin
        r_s     <= r_t;
        r_t     <= w_new_t;
        r_depth <= r_depth + DW'(1);
      end else if (w_pop) begin
        r_t     <= w_new_t;
        r_s     <= w_spill_rd;
        r_depth <= r_depth - DW'(1);
      end else if (w_swap) begin
        r_t <= r_s;
        r_s <= r_t;
      end else if (w_set_t) begin
        r_t <= w_new_t;
      end
      if (w_div_start) r_rem_op <= (w_op == OP_REM);
      r_ovf  <= w_ovf  ? 1'b1 : (w_clr ? 1'b0 : r_ovf);
      r_unf  <= w_unf  ? 1'b1 : (w_clr ? 1'b0 : r_unf);
      r_div0 <= w_div0 ? 1'b1 : (w_clr ? 1'b0 : r_div0);
    end
  end

  assign au.ready_o = w_ready;
  assign au.t_o     = r_t;
  assign au.s_o     = r_s;
  assign au.depth_o = r_depth;
  assign au.ovf_o   = r_ovf;
  assign au.unf_o   = r_unf;
  assign au.div0_o  = r_div0;
endmodule

// File: tb/tb_ej32_au_stk.sv
// Directed plus randomized bench for ej32_au_stk against a queue-based stack model.
module tb_ej32_au_stk;
  localparam int DSZ = 32;
  localparam int DEPTH = 32;
  localparam logic [4:0] NOP = 5'd0, PUSH = 5'd1, DROP = 5'd3, ADD = 5'd6, SUB = 5'd7,
                         DIV = 5'd9, REM = 5'd10, SHR = 5'd15, USHR = 5'd16;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ej32_au_stk_if #(.DSZ(DSZ), .DEPTH(DEPTH)) au();
  ej32_au_stk #(.DSZ(DSZ), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .au(au));

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] m_stk[$];   // m_stk[0] is top of stack
  bit m_ovf, m_unf, m_div0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int need_of(input logic [4:0] op);
    if (op == 2 || op == 3 || op == 17) return 1;
    if (op >= 4 && op <= 16) return 2;
    return 0;
  endfunction

  function automatic int net_of(input logic [4:0] op);
    if (op == 1 || op == 2 || op == 5) return 1;
    if (op == 3 || (op >= 6 && op <= 16)) return -1;
    return 0;
  endfunction

  task automatic check_state(input string tag);
    logic [31:0] et, es;
    et = (m_stk.size() > 0) ? m_stk[0] : 32'd0;
    es = (m_stk.size() > 1) ? m_stk[1] : 32'd0;
    chk({tag, ".t"}, au.t_o, et);
    chk({tag, ".s"}, au.s_o, es);
    chk({tag, ".depth"}, 32'(au.depth_o), 32'(m_stk.size()));
    chk({tag, ".ovf"}, 32'(au.ovf_o), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(au.unf_o), 32'(m_unf));
    chk({tag, ".div0"}, 32'(au.div0_o), 32'(m_div0));
  endtask

  task automatic model_apply(input logic [4:0] op, input logic [31:0] imm, input logic clr,
                             input logic v, output bit div_run);
    logic [31:0] a, b, r;
    int sa, sb;
    bit su, so, sd;
    su = 0; so = 0; sd = 0; div_run = 0;
    if (v) begin
      if (m_stk.size() < need_of(op)) su = 1;
      else if (net_of(op) == 1 && m_stk.size() == DEPTH) so = 1;
      else if (op == 1) m_stk.push_front(imm);
      else if (op == 2) m_stk.push_front(m_stk[0]);
      else if (op == 3) void'(m_stk.pop_front());
      else if (op == 4) begin a = m_stk[0]; m_stk[0] = m_stk[1]; m_stk[1] = a; end
      else if (op == 5) m_stk.push_front(m_stk[1]);
      else if (op == 17) m_stk[0] = 32'd0 - m_stk[0];
      else if (op >= 6 && op <= 16) begin
        b = m_stk.pop_front();
        a = m_stk.pop_front();
        sa = a; sb = b;
        r = 0;
        case (op)
          6: r = a + b;
          7: r = a - b;
          8: r = a * b;
          11: r = a & b;
          12: r = a | b;
          13: r = a ^ b;
          14: r = a << b[4:0];
          15: r = $signed(a) >>> b[4:0];
          16: r = a >> b[4:0];
          default: begin
            if (b == 0) begin
              r = (op == 9) ? 32'hFFFF_FFFF : a;
              sd = 1;
            end else begin
              div_run = 1;
              if (a == MINV && b == 32'hFFFF_FFFF) r = (op == 9) ? MINV : 32'd0;
              else r = (op == 9) ? 32'(sa / sb) : 32'(sa % sb);
            end
          end
        endcase
        m_stk.push_front(r);
      end
    end
    m_unf  = su ? 1'b1 : (clr ? 1'b0 : m_unf);
    m_ovf  = so ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_div0 = sd ? 1'b1 : (clr ? 1'b0 : m_div0);
  endtask

  task automatic step(input string tag, input logic [4:0] op, input logic [31:0] imm,
                      input logic clr, input logic v);
    bit dr;
    int low;
    @(negedge clk);
    au.valid_i = v; au.op_i = op; au.imm_i = imm; au.err_clr = clr;
    @(posedge clk);
    #1;
    au.valid_i = 1'b0; au.err_clr = 1'b0; au.op_i = 5'd0;
    model_apply(op, imm, clr, v, dr);
    if (dr) begin
      low = 0;
      while (!au.ready_o && low < 100) begin
        @(posedge clk);
        #1;
        low++;
      end
      chk({tag, ".busy_cycles"}, 32'(low), 32'd32);
    end else begin
      chk({tag, ".ready"}, 32'(au.ready_o), 32'd1);
    end
    check_state(tag);
    $display("[TB] %s op=%0d v=%0b clr=%0b imm=%h -> t=%h s=%h depth=%0d flags=%b%b%b",
             tag, op, v, clr, imm, au.t_o, au.s_o, au.depth_o, au.ovf_o, au.unf_o, au.div0_o);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    au.valid_i = 1'b0; au.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_stk.delete();
    m_ovf = 0; m_unf = 0; m_div0 = 0;
    #1;
    chk({tag, ".ready"}, 32'(au.ready_o), 32'd1);
    check_state(tag);
  endtask

  initial begin
    logic [4:0] rop;
    logic [31:0] rimm;
    au.valid_i = 1'b0; au.op_i = 5'd0; au.imm_i = '0; au.err_clr = 1'b0;
    do_reset("rst0");

    step("t1.p7", PUSH, 32'd7, 0, 1);
    step("t1.p5", PUSH, 32'd5, 0, 1);
    step("t1.sub", SUB, 32'd0, 0, 1);
    chk("t1.result", au.t_o, 32'd2);

    do_reset("t2.rst");
    for (int i = 1; i <= 32; i++) step($sformatf("t2.push%0d", i), PUSH, 32'(i), 0, 1);
    step("t2.push99", PUSH, 32'd99, 0, 1);
    chk("t2.ovf", 32'(au.ovf_o), 32'd1);
    chk("t2.t_full", au.t_o, 32'd32);
    chk("t2.depth_full", 32'(au.depth_o), 32'd32);
    for (int i = 1; i <= 31; i++) step($sformatf("t2.drop%0d", i), DROP, 32'd0, 0, 1);
    chk("t2.t_bottom", au.t_o, 32'd1);

    do_reset("t3.rst");
    step("t3.add", ADD, 32'd0, 0, 1);
    chk("t3.unf_set", 32'(au.unf_o), 32'd1);
    step("t3.clr", NOP, 32'd0, 1, 0);
    chk("t3.unf_clr", 32'(au.unf_o), 32'd0);
    step("t3.clr_drop", DROP, 32'd0, 1, 1);
    chk("t3.unf_wins", 32'(au.unf_o), 32'd1);

    do_reset("t4.rst");
    step("t4.pm7", PUSH, 32'hFFFF_FFF9, 0, 1);
    step("t4.p2", PUSH, 32'd2, 0, 1);
    step("t4.div", DIV, 32'd0, 0, 1);
    chk("t4.quot", au.t_o, 32'hFFFF_FFFD);
    step("t4.pm7b", PUSH, 32'hFFFF_FFF9, 0, 1);
    step("t4.p2b", PUSH, 32'd2, 0, 1);
    step("t4.rem", REM, 32'd0, 0, 1);
    chk("t4.rem_val", au.t_o, 32'hFFFF_FFFF);

    do_reset("t5.rst");
    step("t5.p9", PUSH, 32'd9, 0, 1);
    step("t5.p0", PUSH, 32'd0, 0, 1);
    step("t5.div0", DIV, 32'd0, 0, 1);
    chk("t5.q_ones", au.t_o, 32'hFFFF_FFFF);
    chk("t5.div0_flag", 32'(au.div0_o), 32'd1);
    step("t5.pmin", PUSH, MINV, 0, 1);
    step("t5.pm1", PUSH, 32'hFFFF_FFFF, 0, 1);
    step("t5.minm1", DIV, 32'd0, 0, 1);
    chk("t5.q_min", au.t_o, MINV);

    do_reset("t6.rst");
    step("t6.pmin", PUSH, MINV, 0, 1);
    step("t6.p4", PUSH, 32'd4, 0, 1);
    step("t6.shr", SHR, 32'd0, 0, 1);
    chk("t6.shr_val", au.t_o, 32'hF800_0000);
    step("t6.pminb", PUSH, MINV, 0, 1);
    step("t6.p4b", PUSH, 32'd4, 0, 1);
    step("t6.ushr", USHR, 32'd0, 0, 1);
    chk("t6.ushr_val", au.t_o, 32'h0800_0000);

    step("t6.p100", PUSH, 32'd100, 0, 1);
    step("t6.p7", PUSH, 32'd7, 0, 1);
    @(negedge clk);
    au.valid_i = 1'b1; au.op_i = DIV;
    @(posedge clk);
    #1;
    au.valid_i = 1'b0; au.op_i = 5'd0;
    repeat (5) @(posedge clk);
    #1;
    chk("t6.busy_mid", 32'(au.ready_o), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    m_stk.delete();
    m_ovf = 0; m_unf = 0; m_div0 = 0;
    chk("t6.abort_ready", 32'(au.ready_o), 32'd1);
    check_state("t6.abort");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t6.ready_after", 32'(au.ready_o), 32'd1);
    check_state("t6.after");

    for (int k = 0; k < 400; k++) begin
      rop = ($urandom_range(0, 99) < 30) ? PUSH : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) rimm = 32'(int'($urandom_range(0, 8)) - 4);
      else rimm = $urandom;
      step($sformatf("rnd%0d", k), rop, rimm, ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
